// File: rtl/sinc3_scheduler_if.sv
// Merged result stream from the sinc3 scheduler to its host: tagged data with a valid/ready handshake.
interface sinc3_scheduler_if #(
    parameter int RES_WIDTH = 25,
    parameter int CH_WIDTH  = 2
);
    logic [RES_WIDTH-1:0] m_data;
    logic [CH_WIDTH-1:0]  m_ch;
    logic                 m_valid;
    logic                 m_ready;

    modport master (output m_data, m_ch, m_valid, input m_ready);
    modport slave  (input m_data, m_ch, m_valid, output m_ready);
endinterface

// File: rtl/sinc3_scheduler.sv
// Settling filter and one-deep result buffer for each sinc3 channel, followed by a
// round-robin merge of all channels into a single tagged valid/ready stream.
module sinc3_sched_lane #(
    parameter int RES_WIDTH = 25,
    parameter int DISCARD   = 4
) (
    input  logic                 clock,
    input  logic                 sclr,
    input  logic                 osr_wr,
    input  logic                 en,
    input  logic                 valid,
    input  logic [RES_WIDTH-1:0] data,
    input  logic                 drain,
    input  logic                 ovf_clr,
    output logic                 full,
    output logic [RES_WIDTH-1:0] slot,
    output logic                 settled,
    output logic                 ovf
);
    localparam int CNT_W = $clog2(DISCARD + 2);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DISCARD);

    logic [CNT_W-1:0] cnt;
    logic             capture;

    assign settled = (cnt == '0);
    // A sample arriving with an OSR change belongs to the old setting and is dropped.
    assign capture = valid & en & settled & ~osr_wr;

    always_ff @(posedge clock) begin
        if (sclr || osr_wr || !en)
            cnt <= CNT_INIT;
        else if (valid && cnt != '0)
            cnt <= cnt - CNT_W'(1);
    end

    always_ff @(posedge clock) begin
        if (sclr || osr_wr || !en)
            full <= 1'b0;
        else if (capture)
            full <= 1'b1;
        else if (drain)
            full <= 1'b0;
    end

    always_ff @(posedge clock) begin
        if (sclr)
            slot <= '0;
        else if (capture)
            slot <= data;
    end

    // Setting an overflow takes priority over clearing it.
    always_ff @(posedge clock) begin
        if (sclr)
            ovf <= 1'b0;
        else if (capture && full && !drain)
            ovf <= 1'b1;
        else if (ovf_clr)
            ovf <= 1'b0;
    end
endmodule

module sinc3_scheduler #(
    parameter int CH_NUM    = 4,
    parameter int OSR_WIDTH = 8,
    parameter int RES_WIDTH = 1 + 3 * OSR_WIDTH,
    parameter int DISCARD   = 4,
    parameter int CH_WIDTH  = $clog2(CH_NUM)
) (
    input  logic                        clock,
    input  logic                        sclr,
    input  logic [OSR_WIDTH-1:0]        osr_in,
    input  logic                        osr_wr,
    output logic [OSR_WIDTH-1:0]        osr,
    input  logic [CH_NUM-1:0]           ch_en,
    input  logic [CH_NUM*RES_WIDTH-1:0] ch_data,
    input  logic [CH_NUM-1:0]           ch_valid,
    sinc3_scheduler_if.master           m,
    output logic [CH_NUM-1:0]           settled,
    output logic [CH_NUM-1:0]           ovf,
    input  logic                        ovf_clr
);
    logic [CH_NUM-1:0]                full, req, drain;
    logic [CH_NUM-1:0][RES_WIDTH-1:0] slot;
    logic [CH_WIDTH-1:0]              ptr, win, ptr_nxt;
    logic                             any, load;
    int                               idx;

    for (genvar k = 0; k < CH_NUM; k++) begin : g_lane
        sinc3_sched_lane #(
            .RES_WIDTH (RES_WIDTH),
            .DISCARD   (DISCARD)
        ) u_lane (
            .clock   (clock),
            .sclr    (sclr),
            .osr_wr  (osr_wr),
            .en      (ch_en[k]),
            .valid   (ch_valid[k]),
            .data    (ch_data[k*RES_WIDTH +: RES_WIDTH]),
            .drain   (drain[k]),
            .ovf_clr (ovf_clr),
            .full    (full[k]),
            .slot    (slot[k]),
            .settled (settled[k]),
            .ovf     (ovf[k])
        );
    end

    // Slots being flushed this cycle must not leak into the output register.
    assign req  = full & ch_en & {CH_NUM{~osr_wr}};
    assign load = ~m.m_valid | m.m_ready;

    always_comb begin
        any   = 1'b0;
        win   = '0;
        idx   = 0;
        drain = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            idx = (int'(ptr) + i) % CH_NUM;
            if (!any && req[idx]) begin
                any = 1'b1;
                win = CH_WIDTH'(idx);
            end
        end
        ptr_nxt = (int'(win) == CH_NUM - 1) ? '0 : win + CH_WIDTH'(1);
        if (load && any)
            drain[win] = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (sclr)
            osr <= '0;
        else if (osr_wr)
            osr <= osr_in;
    end

    always_ff @(posedge clock) begin
        if (sclr) begin
            m.m_valid <= 1'b0;
            m.m_data  <= '0;
            m.m_ch    <= '0;
            ptr       <= '0;
        end else if (load) begin
            if (any) begin
                m.m_valid <= 1'b1;
                m.m_data  <= slot[win];
                m.m_ch    <= win;
                ptr       <= ptr_nxt;
            end else begin
                m.m_valid <= 1'b0;
            end
        end
    end
endmodule
